// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin dmem arbiter with bounded master 1 burst lock
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_we,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,

  input  logic              m1_req,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_we,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,

  output logic [AW-1:0]     daddr,
  output logic [DW-1:0]     dwdata,
  output logic [DW/8-1:0]   dwe,
  input  logic [DW-1:0]     drdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t          r_owner;
  owner_t          w_owner_nxt;
  logic            r_last_winner;   // 1 = master 1 won the last accepted beat
  logic            r_lock_q;
  logic [CW-1:0]   r_burst_cnt;
  logic [CW-1:0]   w_burst_nxt;

  logic            w_lock_hold;
  logic            w_win0;
  logic            w_win1;
  logic            w_acc0;
  logic            w_acc1;
  logic            w_rd0;
  logic            w_rd1;

  logic            r_m0_rvalid;
  logic            r_m1_rvalid;
  logic [DW-1:0]   r_m0_rdata;
  logic [DW-1:0]   r_m1_rdata;

  // Master 1 keeps the bus while it is locked, unless master 0 has waited through a full burst
  assign w_lock_hold = (r_owner == OWN_M1) && r_lock_q && m1_req &&
                       (!m0_req || (r_burst_cnt < BURST_MAX));

  // Winner selection: lock hold, then single requester, then alternate on a tie
  always_comb begin
    w_win0 = 1'b0;
    w_win1 = 1'b0;
    if (w_lock_hold) begin
      w_win1 = 1'b1;
    end else if (m0_req && !m1_req) begin
      w_win0 = 1'b1;
    end else if (m1_req && !m0_req) begin
      w_win1 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (r_last_winner) begin
        w_win0 = 1'b1;
      end else begin
        w_win1 = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing can be accepted
  assign m0_gnt = reset & w_win0;
  assign m1_gnt = reset & w_win1;
  assign w_acc0 = m0_gnt & m0_req;
  assign w_acc1 = m1_gnt & m1_req;
  assign w_rd0  = w_acc0 && (m0_we == '0);
  assign w_rd1  = w_acc1 && (m1_we == '0);

  // Memory port mux: address/data default to master 0, write enables only for a real winner
  always_comb begin
    daddr  = m0_addr;
    dwdata = m0_wdata;
    dwe    = '0;
    if (w_win1) begin
      daddr  = m1_addr;
      dwdata = m1_wdata;
    end
    if (reset) begin
      if (w_win0) begin
        dwe = m0_we;
      end else if (w_win1) begin
        dwe = m1_we;
      end
    end
  end

  // Ownership follows the accepted master and lapses on any idle cycle
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_acc0) begin
      w_owner_nxt = OWN_M0;
    end else if (w_acc1) begin
      w_owner_nxt = OWN_M1;
    end
  end

  // Burst count only advances on locked master 1 beats taken while master 0 is waiting
  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (w_acc0 || (w_owner_nxt != r_owner)) begin
      w_burst_nxt = '0;
    end else if (w_acc1 && w_lock_hold && m0_req && (r_burst_cnt != BURST_MAX)) begin
      w_burst_nxt = r_burst_cnt + CW'(1);
    end
  end

  // Owner state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Arbitration history: last winner, lock flag and burst count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_winner <= 1'b1;
      r_lock_q      <= 1'b0;
      r_burst_cnt   <= '0;
    end else begin
      r_burst_cnt <= w_burst_nxt;
      if (w_acc0) begin
        r_last_winner <= 1'b0;
        r_lock_q      <= 1'b0;
      end else if (w_acc1) begin
        r_last_winner <= 1'b1;
        r_lock_q      <= m1_lock;
      end
    end
  end

  // Read return: capture dmem on the accepting edge, valid for exactly the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_rd0;
      r_m1_rvalid <= w_rd1;
      if (w_rd0) begin
        r_m0_rdata <= drdata;
      end
      if (w_rd1) begin
        r_m1_rdata <= drdata;
      end
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single data memory (dmem: daddr, dwdata, drdata, 4-bit byte-lane dwe) between the CPU load/store port (master 0) and a DMA/debug port (master 1) used for memory preload and dump.
- Arbitration is round-robin, with optional bounded burst locking for master 1.
- Read data is registered and returned one cycle after acceptance.
- Sits between cpu/DMA engine and dmem in the top-level.

Parameters:
AW, 32, address width of masters and memory.
DW, 32, data width; byte-enable width is DW/8.
MAX_BURST, 4, maximum consecutive locked beats granted to master 1 while master 0 is waiting (≥1).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
m0_req  input  1  master 0 request
m0_addr  input  AW  master 0 byte address
m0_wdata  input  DW  master 0 write data
m0_we  input  DW/8  master 0 byte write enables (0 = read)
m0_gnt  output  1  master 0 granted this cycle (combinational)
m0_rvalid  output  1  master 0 read data valid
m0_rdata  output  DW  master 0 read data (registered)
m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for master 1
m1_lock  input  1  master 1 requests to keep ownership for its next beat
daddr  output  AW  to dmem
dwdata  output  DW  to dmem
dwe  output  DW/8  to dmem, byte write enables
drdata  input  DW  from dmem, combinational read of daddr

Behaviour:
- Transfer: accepted on the rising edge where mX_req && mX_gnt. At most one gnt is high per cycle.
- Writes: dmem commits on that same edge.
- Reads: dmem is sampled on that edge into mX_rdata. mX_rvalid is high for exactly the following cycle (latency 1). Back-to-back reads give rvalid every cycle.
- Winner selection (combinational from registered state):
  1. If owner==1, m1_lock was high on the last accepted m1 beat, m1_req=1, and (m0_req=0 or burst_cnt<MAX_BURST), winner is 1.
  2. Else if exactly one req, that master wins.
  3. Else if both req, winner is !last_winner.
  4. Else no winner, gnt both 0.
- dmem mux:
  - daddr/dwdata follow the winner. With no winner they hold the master 0 inputs.
  - dwe = winner's we when a winner exists, else 0.
  - dwe is forced 0 while reset is asserted.
- State registers:
  - last_winner: updated to winner on every accept.
  - owner: set to winner on accept, cleared to "none" when no accept occurs.
  - lock_q: captures m1_lock on each m1 accept, cleared on m0 accept.
  - burst_cnt: +1 on each consecutive locked m1 accept while m0_req=1. Reset to 0 on m0 accept or on any cycle with owner change. Saturates at MAX_BURST.
- Lock cap: when burst_cnt==MAX_BURST and m0_req=1, master 1 loses grant for one cycle. Master 0 is then granted and burst_cnt clears. Master 1 may re-lock afterwards.
- Lock without m0 contention is unbounded; burst_cnt does not advance.
- Req dropped mid-lock: ownership ends and next-cycle arbitration restarts from step 2.
- Reset (async assert, sync deassert by upstream):
  - gnt 0/0, rvalid 0/0, rdata 0/0, dwe 0.
  - last_winner=1 (master 0 wins first tie), owner=none, lock_q=0, burst_cnt=0.
  - Reset mid-burst abandons the burst. In-flight rvalid is suppressed.
- Address/data pass through unchanged. No alignment or range checking.

Test Plan:
- m0 read only: preload mem[0x10]=0xDEADBEEF, m0_req=1, m0_addr=0x10, m0_we=0 -> m0_gnt=1 same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle, m1 outputs idle.
- Byte write: m1 writes 0xAABBCCDD to 0x20 with m1_we=4'b0101 over old 0x11223344 -> dmem word reads 0x11BB33DD.
- Tie round-robin: after reset, both req continuously without lock for 6 cycles -> gnt sequence m0,m1,m0,m1,m0,m1.
- Lock cap: MAX_BURST=4, m1_lock=1 and m1_req=1, m0_req raised during m1 beat 1 -> m1 gets 4 more consecutive beats after m0 raises req, then m0 is granted for one beat, then m1 resumes.
- Lock, no contention: m1 locked for 10 beats with m0_req=0 -> 10 consecutive m1 grants, burst_cnt stays 0.
- Reset mid-burst: drive reset=0 asynchronously during m1 read beat 2 -> gnt, rvalid and dwe fall to 0 immediately, no write lands. After release, the first tie grants m0.
